// File: rtl/rxuart.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling via a down-counting
// baud timer, one-cycle strobes for a good byte or a framing error.
module rxuart #(
    parameter logic [31:0] CLK_PERBAUD = 32'd104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic       o_stb,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam logic [23:0] RELOAD_FULL = 24'(CLK_PERBAUD - 32'd1);
    localparam logic [23:0] RELOAD_HALF = 24'((CLK_PERBAUD / 32'd2) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        stb_q, stb_d;
    logic        ferr_q, ferr_d;
    logic        tick;

    assign tick = (cnt_q == 24'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= 24'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            stb_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            stb_q     <= stb_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // The timer free-runs and reloads a full bit period on every tick;
        // only the start-edge detection loads the half period.
        cnt_d   = tick ? RELOAD_FULL : (cnt_q - 24'd1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        stb_d   = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = RELOAD_HALF;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        stb_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_stb       = stb_q;
    assign o_frame_err = ferr_q;
    assign o_data      = data_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rxuart.sv
// Bench for rxuart: a table of frames plus hand-written glitch, framing-error,
// break and reset sequences, checked through per-instance expectation queues.
`timescale 1ns/1ps
module tb_rxuart;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx8 = 1'b1;
    logic       rx104 = 1'b1;
    logic       stb8, ferr8, busy8;
    logic [7:0] data8;
    logic       stb104, ferr104, busy104;
    logic [7:0] data104;

    always #5 clk = ~clk;

    rxuart #(.CLK_PERBAUD(32'd8)) dut8 (
        .clk(clk), .reset(reset), .i_rx(rx8),
        .o_stb(stb8), .o_data(data8), .o_frame_err(ferr8), .o_busy(busy8)
    );

    rxuart #(.CLK_PERBAUD(32'd104)) dut104 (
        .clk(clk), .reset(reset), .i_rx(rx104),
        .o_stb(stb104), .o_data(data104), .o_frame_err(ferr104), .o_busy(busy104)
    );

    typedef struct {
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         period;
        int         gap;
        logic       chk_spacing;
        logic [7:0] exp_data;
    } vec_t;

    exp_t q8[$];
    exp_t q104[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stb_cyc_last = 0;
    int   stb_cyc_prev = 0;
    logic [7:0] last8 = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (stb8 || ferr8) begin
            checks = checks + 1;
            if (stb8 && ferr8) begin
                failures = failures + 1;
                $display("FAIL overlap8 stb=%0b ferr=%0b required not both", stb8, ferr8);
            end else if (q8.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected8 stb=%0b ferr=%0b data=%h required no pulse", stb8, ferr8, data8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                if (e.ferr != ferr8 || e.data != data8) begin
                    failures = failures + 1;
                    $display("FAIL pulse8 got ferr=%0b data=%h required ferr=%0b data=%h", ferr8, data8, e.ferr, e.data);
                end else begin
                    $display("rx8  %s data=%h at cycle %0d", ferr8 ? "frame_err" : "byte", data8, cyc);
                end
            end
            if (stb8) begin
                stb_cyc_prev = stb_cyc_last;
                stb_cyc_last = cyc;
            end
        end
        if (stb104 || ferr104) begin
            checks = checks + 1;
            if (stb104 && ferr104) begin
                failures = failures + 1;
                $display("FAIL overlap104 stb=%0b ferr=%0b required not both", stb104, ferr104);
            end else if (q104.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected104 stb=%0b ferr=%0b data=%h required no pulse", stb104, ferr104, data104);
            end else begin
                exp_t e;
                e = q104.pop_front();
                if (e.ferr != ferr104 || e.data != data104) begin
                    failures = failures + 1;
                    $display("FAIL pulse104 got ferr=%0b data=%h required ferr=%0b data=%h", ferr104, data104, e.ferr, e.data);
                end else begin
                    $display("rx104 %s data=%h at cycle %0d", ferr104 ? "frame_err" : "byte", data104, cyc);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx8 = v;
        else rx104 = v;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        checks = checks + 1;
        if (got !== req) begin
            failures = failures + 1;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic send(input int which, input logic [7:0] d, input logic stop_bit,
                        input int period, input logic rst_at_start);
        set_rx(which, 1'b0);
        if (rst_at_start) begin
            reset = 1'b1;
            wait_cyc(1);
            reset = 1'b0;
            wait_cyc(period - 1);
        end else begin
            wait_cyc(period);
        end
        for (int b = 0; b < 8; b++) begin
            set_rx(which, d[b]);
            wait_cyc(period);
        end
        set_rx(which, stop_bit);
        wait_cyc(period);
    endtask

    task automatic wait_empty(input int which, input int budget);
        int n;
        n = 0;
        while (n < budget && ((which == 0) ? q8.size() : q104.size()) != 0) begin
            wait_cyc(1);
            n++;
        end
        checks = checks + 1;
        if (((which == 0) ? q8.size() : q104.size()) != 0) begin
            failures = failures + 1;
            $display("FAIL timeout%0d pending=%0d required=0", which,
                     (which == 0) ? q8.size() : q104.size());
        end
    endtask

    vec_t vecs[8];

    initial begin
        int busy_cnt;

        vecs[0] = '{dut: 0, data: 8'hA5, period: 8,   gap: 20,  chk_spacing: 1'b0, exp_data: 8'hA5};
        vecs[1] = '{dut: 0, data: 8'h3C, period: 8,   gap: 0,   chk_spacing: 1'b0, exp_data: 8'h3C};
        vecs[2] = '{dut: 0, data: 8'hC3, period: 8,   gap: 20,  chk_spacing: 1'b1, exp_data: 8'hC3};
        vecs[3] = '{dut: 0, data: 8'h00, period: 8,   gap: 20,  chk_spacing: 1'b0, exp_data: 8'h00};
        vecs[4] = '{dut: 0, data: 8'h81, period: 8,   gap: 20,  chk_spacing: 1'b0, exp_data: 8'h81};
        vecs[5] = '{dut: 0, data: 8'hFF, period: 8,   gap: 20,  chk_spacing: 1'b0, exp_data: 8'hFF};
        vecs[6] = '{dut: 1, data: 8'h24, period: 106, gap: 200, chk_spacing: 1'b0, exp_data: 8'h24};
        vecs[7] = '{dut: 1, data: 8'h24, period: 102, gap: 200, chk_spacing: 1'b0, exp_data: 8'h24};

        // Reset values
        reset = 1'b1;
        wait_cyc(3);
        check("rst_stb8",   {7'd0, stb8},    8'h00);
        check("rst_ferr8",  {7'd0, ferr8},   8'h00);
        check("rst_busy8",  {7'd0, busy8},   8'h00);
        check("rst_data8",  data8,           8'h00);
        check("rst_stb104", {7'd0, stb104},  8'h00);
        check("rst_busy104",{7'd0, busy104}, 8'h00);
        check("rst_data104",data104,         8'h00);
        reset = 1'b0;
        wait_cyc(10);

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.ferr = 1'b0;
            e.data = vecs[i].exp_data;
            if (vecs[i].dut == 0) begin
                q8.push_back(e);
                last8 = vecs[i].exp_data;
            end else begin
                q104.push_back(e);
            end
            send(vecs[i].dut, vecs[i].data, 1'b1, vecs[i].period, 1'b0);
            wait_empty(vecs[i].dut, 40 * vecs[i].period);
            if (vecs[i].chk_spacing) begin
                checks = checks + 1;
                if (stb_cyc_last - stb_cyc_prev != 80) begin
                    failures = failures + 1;
                    $display("FAIL b2b_spacing got=%0d required=80", stb_cyc_last - stb_cyc_prev);
                end
            end
            wait_cyc(vecs[i].gap);
        end
        check("data104_final", data104, 8'h24);

        // Two-cycle glitch is rejected as a false start
        rx8 = 1'b0;
        wait_cyc(2);
        rx8 = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            if (busy8) busy_cnt++;
        end
        checks = checks + 1;
        if (busy_cnt < 1 || busy_cnt > 4) begin
            failures = failures + 1;
            $display("FAIL glitch_busy got=%0d cycles required=1..4", busy_cnt);
        end
        $display("glitch busy cycles=%0d", busy_cnt);

        // Bad stop bit followed by a 40-cycle break: one frame error, data kept
        begin
            exp_t e;
            e.ferr = 1'b1;
            e.data = last8;
            q8.push_back(e);
        end
        send(0, 8'h55, 1'b0, 8, 1'b0);
        wait_cyc(40);
        wait_empty(0, 10);
        check("ferr_data_kept", data8, last8);
        rx8 = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(1);
            if (busy8) busy_cnt++;
        end
        checks = checks + 1;
        if (busy_cnt > 2) begin
            failures = failures + 1;
            $display("FAIL break_release_busy got=%0d cycles required<=2", busy_cnt);
        end
        $display("break release busy cycles=%0d", busy_cnt);
        wait_cyc(20);

        // Reset during data bit 4 of 8'hFF aborts the frame silently
        rx8 = 1'b0;
        wait_cyc(8);
        rx8 = 1'b1;
        wait_cyc(32 + 3);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check("midreset_busy", {7'd0, busy8}, 8'h00);
        check("midreset_data", data8, 8'h00);
        last8 = 8'h00;
        wait_cyc(5 + 24 + 8 + 30);
        check("midreset_idle", {7'd0, busy8}, 8'h00);
        $display("mid-frame reset done");

        // Line already low when reset releases counts as a start bit
        begin
            exp_t e;
            e.ferr = 1'b0;
            e.data = 8'h42;
            q8.push_back(e);
        end
        send(0, 8'h42, 1'b1, 8, 1'b1);
        wait_empty(0, 40);
        wait_cyc(20);

        checks = checks + 1;
        if (q8.size() != 0 || q104.size() != 0) begin
            failures = failures + 1;
            $display("FAIL leftover got=%0d required=0", q8.size() + q104.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
